wb_stage_seq: RTL and testbench
===============================

Name: wb_stage_seq

Overview:
Registered writeback stage for the pipelined RISC-V core. It is the successor of the combinational writeback selector and is parametrised in data width. It selects the register-file write data from ALU result, extended load data, PC+step, PC+C or CSR read data. Unlike the old selector, it waits on variable-latency data-memory load responses, extracts and extends sub-word loads, suppresses x0 writes, and exposes the pending load destination to the hazard unit.

Parameters:
XLEN, 32, datapath width; legal values 32 and 64.
RA_W, 5, register-address width.
PC_STEP, 4, increment used for the link value.

Ports:
clk  in  1  system clock; all state updates on rising edge.
rstn  in  1  reset, asynchronous, active-low.
in_valid  in  1  upstream has a writeback request this cycle.
in_ready  out  1  stage can accept; request taken when in_valid & in_ready.
in_wdsel  in  3  source select: 000 C, 001 load, 010 PC+PC_STEP, 011 PC+C, 100 CSR; 101-111 treated as 010.
in_regwrite  in  1  instruction writes rd.
in_rd  in  RA_W  destination register.
in_c  in  XLEN  ALU result.
in_pc  in  XLEN  instruction PC.
in_csr_rdata  in  XLEN  CSR read value.
in_funct3  in  3  load size/sign: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU.
in_addr_lo  in  3  low bits of the load address; only log2(XLEN/8) LSBs are used.
dm_rvalid  in  1  data-memory read data valid (single-cycle pulse).
dm_rdata  in  XLEN  data-memory read word (naturally aligned).
rf_we  out  1  register-file write enable (one-cycle pulse).
rf_waddr  out  RA_W  write address.
rf_wdata  out  XLEN  write data.
pend_valid  out  1  a load is outstanding.
pend_rd  out  RA_W  rd of the outstanding load.
proto_err  out  1  sticky: dm_rvalid seen while no load is outstanding.

Behaviour:
- Reset (rstn=0, asynchronous): state=IDLE; rf_we=0, rf_waddr=0, rf_wdata=0, pend_valid=0, pend_rd=0, proto_err=0. A load in flight is dropped. A late dm_rvalid after reset release sets proto_err.
- FSM states: IDLE and WAIT. in_ready = (state==IDLE).
- IDLE, accept with in_wdsel!=001:
  - Next edge registers rf_wdata from the selected source.
  - Next edge sets rf_we = in_regwrite & (in_rd!=0) and rf_waddr = in_rd.
  - State stays IDLE. Back-to-back accepts give one write per cycle; latency is 1 cycle.
- IDLE, accept with in_wdsel=001:
  - Capture rd, regwrite, funct3 and addr_lo.
  - Go to WAIT; pend_valid=1; pend_rd=in_rd.
  - rf_we=0 on the next edge.
- WAIT:
  - in_ready=0; in_valid is ignored.
  - On dm_rvalid=1: register the extended load data, set rf_we = regwrite & (rd!=0), clear pend_valid, return to IDLE. The write appears on the edge after dm_rvalid.
  - Earliest new accept is the cycle after that edge.
- dm_rvalid while in IDLE: ignored for data; proto_err set to 1 and held until reset.
- Arithmetic:
  - PC+PC_STEP and PC+C use XLEN-bit modular addition; wrap-around is discarded.
  - CSR and C pass through unmodified.
- Load extraction (off = addr_lo[log2(XLEN/8)-1:0]):
  - Byte lane = dm_rdata[8*off +: 8].
  - Half = dm_rdata[16*(off>>1) +: 16]; off bit0 is ignored.
  - Word = dm_rdata[32*(off>>2) +: 32].
  - LB/LH/LW sign-extend to XLEN; LBU/LHU/LWU zero-extend.
  - LD returns the full word (XLEN=64 only).
  - For XLEN=32: LW and LWU both return the full word; LD and 111 are treated as LW.
  - funct3=111 at XLEN=64 is treated as LD.
- rf_we is a single-cycle pulse and is 0 in every cycle that does not follow an accept or a load completion.
- rf_waddr and rf_wdata hold their last value when rf_we=0.

Test Plan:
- Reset then accept wdsel=000, rd=5, C=0x1234_5678 -> next cycle rf_we=1, waddr=5, wdata=0x12345678; in_ready stays 1. Three back-to-back accepts -> three consecutive write pulses.
- wdsel=010, pc=0xFFFF_FFFC; then wdsel=011, pc=0x100, C=0xFFFF_FF00 -> wdata=0x0000_0000 (wrap); then wdata=0x0000_0000.
- LB, addr_lo=3, dm_rdata=0x80_00_00_00 arriving 4 cycles after accept -> pend_valid=1 and in_ready=0 for 4 cycles; then wdata=0xFFFF_FF80, rf_we pulse, pend_valid=0. Repeat with LBU -> 0x0000_0080. LHU, addr_lo=2, data=0xBEEF_0000 -> 0x0000_BEEF.
- Writes to x0 (wdsel=000 rd=0, and a load with rd=0) -> rf_we stays 0; the load still clears pend_valid on dm_rvalid.
- dm_rvalid pulse in IDLE -> proto_err=1 and stays 1. Load accepted, rstn pulled low before dm_rvalid -> all outputs 0 immediately; dm_rvalid after release -> proto_err=1, rf_we=0.
- XLEN=64 build: LWU, addr_lo=4, data=0x8000_0001_xxxx_xxxx -> 0x0000_0000_8000_0001; LW with the same data -> 0xFFFF_FFFF_8000_0001; LD -> full word.

Source files
------------

// File: rtl/wb_stage_seq.sv
// Registered writeback stage: selects register-file write data, waits on
// variable-latency load responses and extracts/extends sub-word load data.
module wb_stage_seq #(
    parameter int XLEN    = 32,
    parameter int RA_W    = 5,
    parameter int PC_STEP = 4
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_wdsel,
    input  logic            in_regwrite,
    input  logic [RA_W-1:0] in_rd,
    input  logic [XLEN-1:0] in_c,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_csr_rdata,
    input  logic [2:0]      in_funct3,
    input  logic [2:0]      in_addr_lo,
    input  logic            dm_rvalid,
    input  logic [XLEN-1:0] dm_rdata,
    output logic            rf_we,
    output logic [RA_W-1:0] rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            pend_valid,
    output logic [RA_W-1:0] pend_rd,
    output logic            proto_err
);

    localparam int OW = $clog2(XLEN / 8);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t          state_q, state_d;
    logic            rf_we_q, rf_we_d;
    logic [RA_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
    logic [RA_W-1:0] pend_rd_q, pend_rd_d;
    logic            ld_regwrite_q, ld_regwrite_d;
    logic [2:0]      ld_funct3_q, ld_funct3_d;
    logic [OW-1:0]   ld_off_q, ld_off_d;
    logic            proto_err_q, proto_err_d;

    logic [XLEN-1:0] sel_data;
    logic [XLEN-1:0] ld_data;
    logic [OW-1:0]   off_h, off_w;
    logic [7:0]      ld_b;
    logic [15:0]     ld_h;
    logic [31:0]     ld_w;
    logic            unused_addr_hi;

    assign unused_addr_hi = in_addr_lo[2];

    always_comb begin
        sel_data = in_pc + XLEN'(PC_STEP);
        case (in_wdsel)
            3'b000:  sel_data = in_c;
            3'b011:  sel_data = in_pc + in_c;
            3'b100:  sel_data = in_csr_rdata;
            default: sel_data = in_pc + XLEN'(PC_STEP);
        endcase
    end

    // Half/word lanes ignore the offset bits below their own alignment.
    assign off_h = ld_off_q & ~OW'(1);
    assign off_w = ld_off_q & ~OW'(3);
    assign ld_b  = dm_rdata[{ld_off_q, 3'b000} +: 8];
    assign ld_h  = dm_rdata[{off_h, 3'b000} +: 16];
    assign ld_w  = dm_rdata[{off_w, 3'b000} +: 32];

    always_comb begin
        ld_data = XLEN'($signed(ld_w));
        case (ld_funct3_q)
            3'b000:  ld_data = XLEN'($signed(ld_b));
            3'b001:  ld_data = XLEN'($signed(ld_h));
            3'b010:  ld_data = XLEN'($signed(ld_w));
            3'b100:  ld_data = XLEN'(ld_b);
            3'b101:  ld_data = XLEN'(ld_h);
            3'b110:  ld_data = XLEN'(ld_w);
            default: ld_data = (XLEN == 64) ? dm_rdata : XLEN'($signed(ld_w));
        endcase
    end

    always_comb begin
        state_d       = state_q;
        rf_we_d       = 1'b0;
        rf_waddr_d    = rf_waddr_q;
        rf_wdata_d    = rf_wdata_q;
        pend_rd_d     = pend_rd_q;
        ld_regwrite_d = ld_regwrite_q;
        ld_funct3_d   = ld_funct3_q;
        ld_off_d      = ld_off_q;
        proto_err_d   = proto_err_q;
        case (state_q)
            IDLE: begin
                if (dm_rvalid) begin
                    proto_err_d = 1'b1;
                end
                if (in_valid) begin
                    if (in_wdsel == 3'b001) begin
                        state_d       = WAIT;
                        pend_rd_d     = in_rd;
                        ld_regwrite_d = in_regwrite;
                        ld_funct3_d   = in_funct3;
                        ld_off_d      = in_addr_lo[OW-1:0];
                    end else begin
                        rf_we_d    = in_regwrite && (in_rd != '0);
                        rf_waddr_d = in_rd;
                        rf_wdata_d = sel_data;
                    end
                end
            end
            WAIT: begin
                if (dm_rvalid) begin
                    state_d    = IDLE;
                    rf_we_d    = ld_regwrite_q && (pend_rd_q != '0);
                    rf_waddr_d = pend_rd_q;
                    rf_wdata_d = ld_data;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= IDLE;
            rf_we_q       <= 1'b0;
            rf_waddr_q    <= '0;
            rf_wdata_q    <= '0;
            pend_rd_q     <= '0;
            ld_regwrite_q <= 1'b0;
            ld_funct3_q   <= '0;
            ld_off_q      <= '0;
            proto_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            rf_we_q       <= rf_we_d;
            rf_waddr_q    <= rf_waddr_d;
            rf_wdata_q    <= rf_wdata_d;
            pend_rd_q     <= pend_rd_d;
            ld_regwrite_q <= ld_regwrite_d;
            ld_funct3_q   <= ld_funct3_d;
            ld_off_q      <= ld_off_d;
            proto_err_q   <= proto_err_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign pend_valid = (state_q == WAIT);
    assign pend_rd    = pend_rd_q;
    assign rf_we      = rf_we_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_wdata   = rf_wdata_q;
    assign proto_err  = proto_err_q;

endmodule

// File: tb/tb_wb_stage_seq.sv
// Directed bench for wb_stage_seq: a 32-bit and a 64-bit instance share
// clock and reset; each check is an immediate assertion.
module tb_wb_stage_seq;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    // 32-bit instance
    logic        valid = 0, regwrite = 0, dmv = 0;
    logic [2:0]  wdsel = 0, f3 = 0, alo = 0;
    logic [4:0]  rd = 0;
    logic [31:0] c = 0, pc = 0, csr = 0, dmd = 0;
    logic        ready, o_we, o_pv, o_perr;
    logic [4:0]  o_waddr, o_prd;
    logic [31:0] o_wdata;

    // 64-bit instance
    logic        v64 = 0, rw64 = 0, dmv64 = 0;
    logic [2:0]  sel64 = 0, f364 = 0, alo64 = 0;
    logic [4:0]  rd64 = 0;
    logic [63:0] c64 = 0, pc64 = 0, csr64 = 0, dmd64 = 0;
    logic        ready64, we64, pv64, perr64;
    logic [4:0]  waddr64, prd64;
    logic [63:0] wdata64;

    int checks = 0;
    int errors = 0;

    wb_stage_seq #(.XLEN(32), .RA_W(5), .PC_STEP(4)) dut (
        .clk(clk), .rstn(rstn), .in_valid(valid), .in_ready(ready),
        .in_wdsel(wdsel), .in_regwrite(regwrite), .in_rd(rd), .in_c(c),
        .in_pc(pc), .in_csr_rdata(csr), .in_funct3(f3), .in_addr_lo(alo),
        .dm_rvalid(dmv), .dm_rdata(dmd), .rf_we(o_we), .rf_waddr(o_waddr),
        .rf_wdata(o_wdata), .pend_valid(o_pv), .pend_rd(o_prd), .proto_err(o_perr)
    );

    wb_stage_seq #(.XLEN(64), .RA_W(5), .PC_STEP(4)) dut64 (
        .clk(clk), .rstn(rstn), .in_valid(v64), .in_ready(ready64),
        .in_wdsel(sel64), .in_regwrite(rw64), .in_rd(rd64), .in_c(c64),
        .in_pc(pc64), .in_csr_rdata(csr64), .in_funct3(f364), .in_addr_lo(alo64),
        .dm_rvalid(dmv64), .dm_rdata(dmd64), .rf_we(we64), .rf_waddr(waddr64),
        .rf_wdata(wdata64), .pend_valid(pv64), .pend_rd(prd64), .proto_err(perr64)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [2:0] s, input logic rw, input logic [4:0] r,
                       input logic [31:0] cv, input logic [31:0] pcv, input logic [31:0] csrv);
        valid = 1; wdsel = s; regwrite = rw; rd = r; c = cv; pc = pcv; csr = csrv;
    endtask

    task automatic wr_check(input string tag, input logic we, input logic [4:0] wa,
                            input logic [31:0] wd);
        chk({tag, ".we"}, 64'(o_we), 64'(we));
        if (we) chk({tag, ".waddr"}, 64'(o_waddr), 64'(wa));
        chk({tag, ".wdata"}, 64'(o_wdata), 64'(wd));
        $display("txn %s: we=%0d waddr=%0d wdata=%h", tag, o_we, o_waddr, o_wdata);
    endtask

    task automatic load(input bit w64, input logic [2:0] fn, input logic [2:0] a,
                        input logic [4:0] r, input logic rw, input logic [63:0] data,
                        input int lat, input logic exp_we, input logic [63:0] exp_d,
                        input string tag);
        if (!w64) begin
            valid = 1; wdsel = 3'b001; regwrite = rw; rd = r; f3 = fn; alo = a;
        end else begin
            v64 = 1; sel64 = 3'b001; rw64 = rw; rd64 = r; f364 = fn; alo64 = a;
        end
        tick;
        valid = 0; v64 = 0;
        for (int i = 0; i < lat; i++) begin
            chk({tag, ".pend_valid"}, 64'(w64 ? pv64 : o_pv), 64'd1);
            chk({tag, ".in_ready"}, 64'(w64 ? ready64 : ready), 64'd0);
            chk({tag, ".pend_rd"}, 64'(w64 ? prd64 : o_prd), 64'(r));
            chk({tag, ".we_wait"}, 64'(w64 ? we64 : o_we), 64'd0);
            if (!w64 && i == 0) begin
                // a request offered during WAIT must be ignored
                valid = 1; wdsel = 3'b000; regwrite = 1; rd = 5'd9; c = 32'h5555_AAAA;
            end
            if (i < lat - 1) tick;
        end
        valid = 0;
        if (!w64) begin dmv = 1; dmd = data[31:0]; end
        else begin dmv64 = 1; dmd64 = data; end
        tick;
        dmv = 0; dmv64 = 0;
        chk({tag, ".we"}, 64'(w64 ? we64 : o_we), 64'(exp_we));
        if (exp_we) begin
            chk({tag, ".waddr"}, 64'(w64 ? waddr64 : o_waddr), 64'(r));
            chk({tag, ".wdata"}, w64 ? wdata64 : 64'(o_wdata), exp_d);
        end
        chk({tag, ".pend_clr"}, 64'(w64 ? pv64 : o_pv), 64'd0);
        chk({tag, ".ready"}, 64'(w64 ? ready64 : ready), 64'd1);
        $display("txn %s: we=%0d wdata=%h", tag, w64 ? we64 : o_we,
                 w64 ? wdata64 : 64'(o_wdata));
        tick;
        chk({tag, ".we_pulse"}, 64'(w64 ? we64 : o_we), 64'd0);
    endtask

    initial begin
        tick; tick;
        chk("rst.we", 64'(o_we), 0);
        chk("rst.waddr", 64'(o_waddr), 0);
        chk("rst.wdata", 64'(o_wdata), 0);
        chk("rst.pend", 64'(o_pv), 0);
        chk("rst.perr", 64'(o_perr), 0);
        chk("rst.ready", 64'(ready), 1);
        rstn = 1;
        tick;

        req(3'b000, 1, 5'd5, 32'h1234_5678, 0, 0);
        chk("alu.ready_pre", 64'(ready), 1);
        tick; valid = 0;
        wr_check("alu", 1, 5'd5, 32'h1234_5678);
        chk("alu.ready", 64'(ready), 1);

        req(3'b000, 1, 5'd1, 32'h11, 0, 0);
        tick; wr_check("b2b1", 1, 5'd1, 32'h11);
        req(3'b000, 1, 5'd2, 32'h22, 0, 0);
        tick; wr_check("b2b2", 1, 5'd2, 32'h22);
        req(3'b000, 1, 5'd3, 32'h33, 0, 0);
        tick; wr_check("b2b3", 1, 5'd3, 32'h33);
        valid = 0;
        tick; chk("b2b.idle_we", 64'(o_we), 0);
        chk("hold.wdata", 64'(o_wdata), 64'h33);

        req(3'b010, 1, 5'd6, 32'h0, 32'hFFFF_FFFC, 0);
        tick; wr_check("pc4wrap", 1, 5'd6, 32'h0);
        req(3'b011, 1, 5'd7, 32'hFFFF_FF00, 32'h100, 0);
        tick; wr_check("pccwrap", 1, 5'd7, 32'h0);
        req(3'b100, 1, 5'd8, 32'h0, 32'h0, 32'hCAFE_F00D);
        tick; wr_check("csr", 1, 5'd8, 32'hCAFE_F00D);
        req(3'b111, 1, 5'd9, 32'h0, 32'h1000, 0);
        tick; wr_check("sel111", 1, 5'd9, 32'h1004);
        req(3'b000, 0, 5'd10, 32'h77, 0, 0);
        tick; chk("norw.we", 64'(o_we), 0);
        req(3'b000, 1, 5'd0, 32'hABC, 0, 0);
        tick; valid = 0;
        chk("x0.we", 64'(o_we), 0);
        tick;

        load(0, 3'b000, 3'd3, 5'd7, 1, 64'h8000_0000, 4, 1, 64'hFFFF_FF80, "lb");
        load(0, 3'b100, 3'd3, 5'd7, 1, 64'h8000_0000, 4, 1, 64'h0000_0080, "lbu");
        load(0, 3'b101, 3'd2, 5'd11, 1, 64'hBEEF_0000, 2, 1, 64'h0000_BEEF, "lhu");
        load(0, 3'b001, 3'd1, 5'd12, 1, 64'h1234_8001, 1, 1, 64'hFFFF_8001, "lh_odd");
        load(0, 3'b100, 3'd1, 5'd13, 1, 64'h0000_A500, 1, 1, 64'h0000_00A5, "lbu1");
        load(0, 3'b111, 3'd1, 5'd14, 1, 64'h89AB_CDEF, 3, 1, 64'h89AB_CDEF, "lw111");
        load(0, 3'b011, 3'd0, 5'd15, 1, 64'h8765_4321, 1, 1, 64'h8765_4321, "ld32");
        load(0, 3'b010, 3'd0, 5'd0, 1, 64'hFFFF_FFFF, 2, 0, 64'h0, "ld_x0");

        load(1, 3'b110, 3'd4, 5'd20, 1, 64'h8000_0001_1234_5678, 2, 1,
             64'h0000_0000_8000_0001, "lwu64");
        load(1, 3'b010, 3'd4, 5'd21, 1, 64'h8000_0001_1234_5678, 1, 1,
             64'hFFFF_FFFF_8000_0001, "lw64");
        load(1, 3'b011, 3'd4, 5'd22, 1, 64'h8000_0001_1234_5678, 1, 1,
             64'h8000_0001_1234_5678, "ld64");
        load(1, 3'b111, 3'd0, 5'd23, 1, 64'hDEAD_BEEF_0BAD_F00D, 1, 1,
             64'hDEAD_BEEF_0BAD_F00D, "f7_64");
        load(1, 3'b000, 3'd7, 5'd24, 1, 64'h8000_0000_0000_0000, 1, 1,
             64'hFFFF_FFFF_FFFF_FF80, "lb64");
        load(1, 3'b001, 3'd7, 5'd25, 1, 64'hBEEF_0000_0000_0000, 1, 1,
             64'hFFFF_FFFF_FFFF_BEEF, "lh64");

        chk("perr.clean", 64'(o_perr), 0);
        dmv = 1; dmd = 32'hFFFF_FFFF;
        tick; dmv = 0;
        chk("perr.set", 64'(o_perr), 1);
        chk("perr.we", 64'(o_we), 0);
        tick; tick;
        chk("perr.sticky", 64'(o_perr), 1);
        $display("txn proto_err: perr=%0d", o_perr);

        valid = 1; wdsel = 3'b001; regwrite = 1; rd = 5'd17; f3 = 3'b010; alo = 0;
        tick; valid = 0;
        chk("rstld.pend", 64'(o_pv), 1);
        #2 rstn = 0;
        #1;
        chk("arst.we", 64'(o_we), 0);
        chk("arst.waddr", 64'(o_waddr), 0);
        chk("arst.wdata", 64'(o_wdata), 0);
        chk("arst.pend", 64'(o_pv), 0);
        chk("arst.prd", 64'(o_prd), 0);
        chk("arst.perr", 64'(o_perr), 0);
        chk("arst.ready", 64'(ready), 1);
        chk("arst.wdata64", wdata64, 0);
        tick;
        rstn = 1;
        tick;
        dmv = 1; dmd = 32'h1111_2222;
        tick; dmv = 0;
        chk("late.perr", 64'(o_perr), 1);
        chk("late.we", 64'(o_we), 0);
        chk("late.pend", 64'(o_pv), 0);
        $display("txn late_rvalid: perr=%0d we=%0d", o_perr, o_we);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
